// File: rtl/uart_tx_engine.sv
// UART transmit path: 16x baud generator, TX FIFO / holding register and the
// frame serialiser that drives TXD and the LSR THRE/TEMT status.
module uart_tx_engine #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_thr_write,
    input  logic [7:0]  i_thr_data,
    input  logic        i_fifo_enable,
    input  logic        i_xmit_fifo_reset,
    input  logic [1:0]  i_wls,
    input  logic        i_stb,
    input  logic        i_pen,
    input  logic        i_eps,
    input  logic        i_stick_parity,
    input  logic        i_set_break,
    input  logic [15:0] i_divisor,
    output logic        o_baud_tick,
    output logic        o_txd,
    output logic        o_thre,
    output logic        o_temt,
    output logic        o_thre_event
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] wls,
                                        input logic eps, input logic stick);
        logic x;
        x = ^(data & (8'hFF >> (2'd3 - wls)));
        if (stick) return ~eps;
        return eps ? x : ~x;
    endfunction

    // Index of the final stop tick: 1, 1.5 or 2 stop bits.
    function automatic logic [4:0] stop_last(input logic stb, input logic [1:0] wls);
        if (!stb) return 5'd15;
        if (wls == 2'b00) return 5'd23;
        return 5'd31;
    endfunction

    logic [15:0]   cnt_q, cnt_d;
    logic          tick_q, tick_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          fifo_en_q, fifo_en_d;
    state_t        state_q, state_d;
    logic [4:0]    tcnt_q, tcnt_d;
    logic [2:0]    bcnt_q, bcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [1:0]    wls_q, wls_d;
    logic          pen_q, pen_d, stb_q, stb_d, par_q, par_d;
    logic          txd_q, txd_d;
    logic          thre_prev_q, thre_prev_d, thre_ev_q, thre_ev_d;
    logic          flush, empty, full, pop, wr_ok, line;
    logic [7:0]    head;

    assign head  = mem_q[rd_ptr_q];
    assign flush = i_xmit_fifo_reset | (i_fifo_enable != fifo_en_q);
    assign empty = (count_q == '0);
    assign full  = fifo_en_q ? (count_q == CW'(FIFO_DEPTH)) : !empty;

    always_comb begin
        cnt_d       = cnt_q;
        tick_d      = 1'b0;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        fifo_en_d   = i_fifo_enable;
        state_d     = state_q;
        tcnt_d      = tcnt_q;
        bcnt_d      = bcnt_q;
        shift_d     = shift_q;
        wls_d       = wls_q;
        pen_d       = pen_q;
        stb_d       = stb_q;
        par_d       = par_q;
        pop         = 1'b0;
        wr_ok       = 1'b0;
        line        = 1'b1;

        if (i_divisor == 16'd0) begin
            cnt_d = 16'd0;
        end else if (cnt_q == 16'd0) begin
            tick_d = 1'b1;
            cnt_d  = i_divisor - 16'd1;
        end else begin
            cnt_d = cnt_q - 16'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (tick_q && !empty && !flush) begin
                    pop     = 1'b1;
                    state_d = S_START;
                    tcnt_d  = 5'd0;
                end
            end
            S_START: begin
                line = 1'b0;
                if (tick_q) begin
                    tcnt_d = tcnt_q + 5'd1;
                    if (tcnt_q == 5'd15) begin
                        tcnt_d  = 5'd0;
                        bcnt_d  = 3'd0;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                line = shift_q[0];
                if (tick_q) begin
                    tcnt_d = tcnt_q + 5'd1;
                    if (tcnt_q == 5'd15) begin
                        tcnt_d  = 5'd0;
                        shift_d = {1'b0, shift_q[7:1]};
                        bcnt_d  = bcnt_q + 3'd1;
                        if (bcnt_q == 3'd4 + {1'b0, wls_q})
                            state_d = pen_q ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                line = par_q;
                if (tick_q) begin
                    tcnt_d = tcnt_q + 5'd1;
                    if (tcnt_q == 5'd15) begin
                        tcnt_d  = 5'd0;
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (tick_q) begin
                    tcnt_d = tcnt_q + 5'd1;
                    if (tcnt_q == stop_last(stb_q, wls_q)) begin
                        tcnt_d  = 5'd0;
                        state_d = S_IDLE;
                        // Back-to-back frames: next start bit follows the stop bit directly.
                        if (!empty && !flush) begin
                            pop     = 1'b1;
                            state_d = S_START;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (pop) begin
            shift_d = head;
            wls_d   = i_wls;
            pen_d   = i_pen;
            stb_d   = i_stb;
            par_d   = parity_bit(head, i_wls, i_eps, i_stick_parity);
        end

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ok    = i_thr_write && (!full || pop);
            wr_ptr_d = wr_ptr_q + AW'(wr_ok);
            rd_ptr_d = rd_ptr_q + AW'(pop);
            count_d  = count_q + CW'(wr_ok) - CW'(pop);
        end

        txd_d       = i_set_break ? 1'b0 : line;
        thre_prev_d = empty;
        thre_ev_d   = empty && !thre_prev_q;
    end

    always_ff @(posedge i_clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= i_thr_data;
    end

    always_ff @(posedge i_clk) begin
        shift_q <= shift_d;
        wls_q   <= wls_d;
        pen_q   <= pen_d;
        stb_q   <= stb_d;
        par_q   <= par_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q       <= 16'd0;
            tick_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            fifo_en_q   <= i_fifo_enable;
            state_q     <= S_IDLE;
            tcnt_q      <= 5'd0;
            bcnt_q      <= 3'd0;
            txd_q       <= 1'b1;
            thre_prev_q <= 1'b1;
            thre_ev_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            tick_q      <= tick_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            fifo_en_q   <= fifo_en_d;
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            bcnt_q      <= bcnt_d;
            txd_q       <= txd_d;
            thre_prev_q <= thre_prev_d;
            thre_ev_q   <= thre_ev_d;
        end
    end

    assign o_baud_tick  = tick_q;
    assign o_txd        = txd_q;
    assign o_thre       = empty;
    assign o_temt       = empty && (state_q == S_IDLE);
    assign o_thre_event = thre_ev_q;
endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: frames queued at write time are
// compared cycle-by-cycle against the serial line as they are transmitted.
module tb_uart_tx_engine;
    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_thr_write = 1'b0;
    logic [7:0]  i_thr_data = 8'h00;
    logic        i_fifo_enable = 1'b0;
    logic        i_xmit_fifo_reset = 1'b0;
    logic [1:0]  i_wls = 2'b11;
    logic        i_stb = 1'b0;
    logic        i_pen = 1'b0;
    logic        i_eps = 1'b0;
    logic        i_stick_parity = 1'b0;
    logic        i_set_break = 1'b0;
    logic [15:0] i_divisor = 16'd1;
    logic        o_baud_tick, o_txd, o_thre, o_temt, o_thre_event;

    uart_tx_engine #(.FIFO_DEPTH(16)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_thr_write(i_thr_write), .i_thr_data(i_thr_data),
        .i_fifo_enable(i_fifo_enable), .i_xmit_fifo_reset(i_xmit_fifo_reset),
        .i_wls(i_wls), .i_stb(i_stb), .i_pen(i_pen), .i_eps(i_eps),
        .i_stick_parity(i_stick_parity), .i_set_break(i_set_break), .i_divisor(i_divisor),
        .o_baud_tick(o_baud_tick), .o_txd(o_txd), .o_thre(o_thre), .o_temt(o_temt),
        .o_thre_event(o_thre_event)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [7:0] data;
        logic [1:0] wls;
        logic       pen, eps, stick, stb;
    } frame_t;

    frame_t exp_q[$];
    int     errors = 0;
    int     checks = 0;
    int     cyc = 0;
    int     ev_cnt = 0;
    int     cur_div = 1;
    logic   thre_after = 1'b0;

    always @(posedge i_clk) cyc <= cyc + 1;
    always @(negedge i_clk) if (o_thre_event === 1'b1) ev_cnt <= ev_cnt + 1;

    function automatic logic model_parity(frame_t f);
        logic x = 1'b0;
        for (int b = 0; b < 5 + int'(f.wls); b++) x ^= f.data[b];
        if (f.stick) return ~f.eps;
        return f.eps ? x : ~x;
    endfunction

    function automatic int frame_ticks(frame_t f);
        int stop = !f.stb ? 16 : (f.wls == 2'b00 ? 24 : 32);
        return 16 + 16 * (5 + int'(f.wls)) + (f.pen ? 16 : 0) + stop;
    endfunction

    function automatic logic exp_bit(frame_t f, int t);
        int n = 5 + int'(f.wls);
        if (t < 16) return 1'b0;
        t -= 16;
        if (t < 16 * n) return f.data[t / 16];
        t -= 16 * n;
        if (f.pen && t < 16) return model_parity(f);
        return 1'b1;
    endfunction

    task automatic set_cfg(input logic [1:0] wls, input logic pen, input logic eps,
                           input logic stick, input logic stb, input int div);
        i_wls = wls; i_pen = pen; i_eps = eps; i_stick_parity = stick; i_stb = stb;
        i_divisor = 16'(div);
        cur_div = div;
    endtask

    // Drives one write cycle; consecutive calls give back-to-back writes.
    task automatic wr(input logic [7:0] d, input bit expect_sent);
        frame_t f;
        i_thr_write = 1'b1;
        i_thr_data  = d;
        if (expect_sent) begin
            f.data = d; f.wls = i_wls; f.pen = i_pen; f.eps = i_eps;
            f.stick = i_stick_parity; f.stb = i_stb;
            exp_q.push_back(f);
        end
        @(negedge i_clk);
        i_thr_write = 1'b0;
    endtask

    // act 1: break asserted for act_len cycles from act_idx; act 2: xmit FIFO reset pulse.
    task automatic check_frame(input string name, input int act, input int act_idx,
                               input int act_len, output int start_cyc, output int len,
                               output int temt_hits);
        frame_t f;
        int     waited = 0;
        int     mism = 0;
        int     first = -1;
        logic   e;
        start_cyc = -1; len = 0; temt_hits = 0;
        while (o_txd !== 1'b0 && waited < 5000) begin
            @(negedge i_clk);
            waited++;
        end
        if (waited >= 5000) begin
            checks++; errors++;
            $display("FAIL %s: no start bit within 5000 cycles (txd=%b), required falling edge", name, o_txd);
            return;
        end
        if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s: frame started at cycle %0d, required no frame", name, cyc);
            return;
        end
        f = exp_q.pop_front();
        len = frame_ticks(f) * cur_div;
        start_cyc = cyc;
        for (int i = 0; i < len; i++) begin
            e = exp_bit(f, i / cur_div);
            if (act == 1 && i > act_idx && i <= act_idx + act_len) e = 1'b0;
            if (o_txd !== e) begin
                mism++;
                if (first < 0) first = i;
            end
            if (i < len - 1 && o_temt === 1'b1) temt_hits++;
            if (act == 2 && i == act_idx + 1) thre_after = o_thre;
            i_set_break       = (act == 1 && i >= act_idx && i < act_idx + act_len);
            i_xmit_fifo_reset = (act == 2 && i == act_idx);
            if (i < len - 1) @(negedge i_clk);
        end
        i_set_break = 1'b0;
        i_xmit_fifo_reset = 1'b0;
        checks++;
        if (mism != 0) begin
            errors++;
            $display("FAIL %s: data 0x%02h has %0d wrong txd cycles (first at cycle %0d of %0d), required 0",
                     name, f.data, mism, first, len);
        end
    endtask

    task automatic check_idle(input string name, input int n);
        int lows = 0;
        repeat (n) begin
            @(negedge i_clk);
            if (o_txd !== 1'b1) lows++;
        end
        checks++;
        if (lows != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d low txd cycles, %0d frames outstanding, required 0 and 0",
                     name, lows, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic expect1(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b, required %b", name, got, want);
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (3) @(negedge i_clk);
        expect1("reset_txd", o_txd, 1'b1);
        expect1("reset_thre", o_thre, 1'b1);
        expect1("reset_temt", o_temt, 1'b1);
        expect1("reset_tick", o_baud_tick, 1'b0);
        expect1("reset_event", o_thre_event, 1'b0);
        i_rst = 1'b0;
        repeat (4) @(negedge i_clk);
    endtask

    task automatic test_basic_8n1();
        int s, l, th, ev0;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        repeat (4) @(negedge i_clk);
        ev0 = ev_cnt;
        wr(8'hA5, 1'b1);
        expect1("basic_thre_after_write", o_thre, 1'b0);
        @(negedge i_clk);
        expect1("basic_thre_at_pop", o_thre, 1'b1);
        check_frame("basic_frame", 0, 0, 0, s, l, th);
        checks++;
        if (th != 0) begin
            errors++;
            $display("FAIL basic_temt_in_frame: temt high %0d cycles, required 0", th);
        end
        repeat (3) @(negedge i_clk);
        expect1("basic_temt_after", o_temt, 1'b1);
        checks++;
        if (ev_cnt - ev0 != 1) begin
            errors++;
            $display("FAIL basic_thre_event: %0d pulses, required 1", ev_cnt - ev0);
        end
    endtask

    task automatic test_parity_5e15();
        int t0, w, s, l, th;
        set_cfg(2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 3);
        repeat (8) @(negedge i_clk);
        w = 0;
        while (o_baud_tick !== 1'b1 && w < 20) begin @(negedge i_clk); w++; end
        t0 = cyc;
        @(negedge i_clk);
        w = 0;
        while (o_baud_tick !== 1'b1 && w < 20) begin @(negedge i_clk); w++; end
        checks++;
        if (cyc - t0 != 3) begin
            errors++;
            $display("FAIL tick_period: got %0d cycles, required 3", cyc - t0);
        end
        wr(8'h13, 1'b1);
        check_frame("parity_5e15_frame", 0, 0, 0, s, l, th);
        check_idle("parity_5e15_idle", 100);
    endtask

    task automatic test_fifo_burst();
        int s, l, th, ps, pl, gaps, thsum;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        i_fifo_enable = 1'b1;
        repeat (4) @(negedge i_clk);
        gaps = 0; thsum = 0; ps = 0; pl = 0;
        fork
            begin
                for (int k = 0; k < 17; k++) wr(8'(k), 1'b1);
            end
            begin
                for (int k = 0; k < 17; k++) begin
                    check_frame("burst_frame", 0, 0, 0, s, l, th);
                    if (k > 0 && s != ps + pl) gaps++;
                    thsum += th;
                    ps = s; pl = l;
                end
            end
        join
        checks++;
        if (gaps != 0) begin
            errors++;
            $display("FAIL burst_contiguous: %0d gaps between frames, required 0", gaps);
        end
        checks++;
        if (thsum != 0) begin
            errors++;
            $display("FAIL burst_temt: temt high %0d cycles during burst, required 0", thsum);
        end
        repeat (3) @(negedge i_clk);
        expect1("burst_temt_after", o_temt, 1'b1);
        check_idle("burst_idle", 200);
    endtask

    task automatic test_holding_reg();
        int s, l, th;
        i_fifo_enable = 1'b0;
        repeat (4) @(negedge i_clk);
        fork
            begin
                wr(8'h3C, 1'b1);
                repeat (40) @(negedge i_clk);
                wr(8'hC3, 1'b1);
                expect1("holding_thre_full", o_thre, 1'b0);
                wr(8'h99, 1'b0);
            end
            begin
                check_frame("holding_first", 0, 0, 0, s, l, th);
                check_frame("holding_second", 0, 0, 0, s, l, th);
            end
        join
        check_idle("holding_drop", 300);
    endtask

    task automatic test_xmit_reset();
        int s, l, th, ev0;
        i_fifo_enable = 1'b1;
        i_divisor = 16'd0;
        repeat (4) @(negedge i_clk);
        wr(8'h81, 1'b1);
        for (int k = 0; k < 5; k++) wr(8'(8'h90 + k), 1'b0);
        expect1("xrst_thre_queued", o_thre, 1'b0);
        ev0 = ev_cnt;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        check_frame("xrst_frame", 2, 60, 0, s, l, th);
        expect1("xrst_thre_next", thre_after, 1'b1);
        checks++;
        if (ev_cnt - ev0 != 1) begin
            errors++;
            $display("FAIL xrst_thre_event: %0d pulses, required 1", ev_cnt - ev0);
        end
        check_idle("xrst_idle", 400);
    endtask

    task automatic test_stick_break();
        int s, l, th;
        set_cfg(2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 2);
        repeat (4) @(negedge i_clk);
        wr(8'h5A, 1'b1);
        check_frame("stick_break_frame", 1, 69, 25, s, l, th);
        check_idle("stick_break_idle", 100);
    endtask

    task automatic test_divisor_zero();
        int ticks, changes, w;
        logic v;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2);
        repeat (4) @(negedge i_clk);
        wr(8'hF0, 1'b0);
        repeat (100) @(negedge i_clk);
        i_divisor = 16'd0;
        repeat (3) @(negedge i_clk);
        v = o_txd;
        ticks = 0; changes = 0;
        repeat (100) begin
            @(negedge i_clk);
            if (o_baud_tick === 1'b1) ticks++;
            if (o_txd !== v) changes++;
        end
        checks++;
        if (ticks != 0) begin
            errors++;
            $display("FAIL div0_ticks: got %0d ticks, required 0", ticks);
        end
        checks++;
        if (changes != 0) begin
            errors++;
            $display("FAIL div0_txd_frozen: txd changed %0d times, required 0", changes);
        end
        expect1("div0_temt_frozen", o_temt, 1'b0);
        i_divisor = 16'd2;
        w = 0;
        while (o_temt !== 1'b1 && w < 1000) begin @(negedge i_clk); w++; end
        expect1("div0_resume_done", o_temt, 1'b1);
    endtask

    task automatic test_reset_midframe();
        int ev0;
        i_fifo_enable = 1'b1;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        repeat (4) @(negedge i_clk);
        wr(8'h00, 1'b0);
        wr(8'h22, 1'b0);
        repeat (20) @(negedge i_clk);
        expect1("rst_mid_txd_low", o_txd, 1'b0);
        ev0 = ev_cnt;
        i_rst = 1'b1;
        @(negedge i_clk);
        expect1("rst_mid_txd", o_txd, 1'b1);
        expect1("rst_mid_thre", o_thre, 1'b1);
        expect1("rst_mid_temt", o_temt, 1'b1);
        i_rst = 1'b0;
        repeat (3) @(negedge i_clk);
        checks++;
        if (ev_cnt - ev0 != 0) begin
            errors++;
            $display("FAIL rst_mid_event: %0d pulses, required 0", ev_cnt - ev0);
        end
        check_idle("rst_mid_idle", 300);
    endtask

    initial begin
        @(negedge i_clk);
        test_reset();
        test_basic_8n1();
        test_parity_5e15();
        test_fifo_burst();
        test_holding_reg();
        test_xmit_reset();
        test_stick_break();
        test_divisor_zero();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
